// File: rtl/cpu_pkg.sv
// Shared encodings for the data-memory path: access sizes, controller states
// and the access legality check.
package cpu_pkg;

  localparam logic [1:0] DM_WORD = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_BYTE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // An access is rejected when it asks for both directions at once, uses the
  // reserved size code, or is not naturally aligned for its size.
  function automatic logic access_bad(input logic       rd,
                                      input logic       wr,
                                      input logic [1:0] size,
                                      input logic [1:0] lane);
    logic bad;
    case (size)
      DM_WORD: bad = (lane != 2'b00);
      DM_HALF: bad = lane[0];
      DM_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad | (rd & wr);
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are never cleared.
module dmem_lane_ram #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory controller with configurable wait states: accepts one access,
// counts down, then completes with a one-cycle ready pulse (err on rejects).
module dmem_wait_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DEPTH       = 2048,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  dm_bit,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q, size_q;
  logic [31:0]      wdata_q, hold_q;
  logic             sext_q, wr_q, bad_q;

  logic             accept;
  logic [IDX_W-1:0] raddr;
  logic [31:0]      ram_rdata, ram_wdata, load_data;
  logic [3:0]       be, ram_we;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             unused_addr;

  assign accept      = (state_q == ST_IDLE) && cs && (rd || wr);
  assign unused_addr = ^addr[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_INIT == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q <= wr;
        bad_q <= access_bad(rd, wr, dm_bit, addr[1:0]);
      end
      if (state_q == ST_DONE) hold_q <= load_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      idx_q   <= addr[ADDR_W-1:2];
      lane_q  <= addr[1:0];
      size_q  <= dm_bit;
      sext_q  <= sext;
      wdata_q <= wdata;
    end
  end

  // While idle the RAM tracks the incoming address so a zero-wait read has
  // its data ready in the cycle right after accept.
  assign raddr = (state_q == ST_IDLE) ? addr[ADDR_W-1:2] : idx_q;

  always_comb begin
    be        = 4'b0000;
    ram_wdata = wdata_q;
    case (size_q)
      DM_WORD: be = 4'b1111;
      DM_HALF: begin
        be        = lane_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      DM_BYTE: begin
        be        = 4'b0001 << lane_q;
        ram_wdata = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  assign ram_we = (reset && state_q == ST_DONE && wr_q && !bad_q) ? be : 4'b0000;

  dmem_lane_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (ram_we),
    .waddr_i (idx_q),
    .wdata_i (ram_wdata),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    case (lane_q)
      2'd0:    byte_v = ram_rdata[7:0];
      2'd1:    byte_v = ram_rdata[15:8];
      2'd2:    byte_v = ram_rdata[23:16];
      default: byte_v = ram_rdata[31:24];
    endcase
    half_v = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      DM_WORD: load_data = ram_rdata;
      DM_HALF: load_data = {{16{sext_q & half_v[15]}}, half_v};
      DM_BYTE: load_data = {{24{sext_q & byte_v[7]}}, byte_v};
      default: load_data = 32'd0;
    endcase
    if (bad_q) load_data = 32'd0;
  end

  assign ready     = (state_q == ST_DONE);
  assign err       = ready & bad_q;
  assign busy      = (state_q != ST_IDLE);
  assign rdata     = ready ? load_data : hold_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Scoreboard bench for dmem_wait_ctrl: one instance with two wait states and
// one with none, driven by directed accesses with hand-computed results.
module tb_dmem_wait_ctrl;

  localparam int W0 = 2;
  localparam int W1 = 0;

  // Handshake: a request is offered with cs && (rd || wr) for one cycle while
  // the block is idle; completion is the single cycle where ready is high, and
  // rdata/err are only meaningful in that cycle.
  logic             clk, reset;
  logic [1:0]       cs, rd, wr, sext, ready, busy, err;
  logic [1:0][1:0]  dm, st;
  logic [1:0][31:0] addr, wdata, rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // entry: {check_rdata, exp_err, exp_rdata[31:0], issue_cycle[15:0]}
  logic [49:0] exp_q[$];
  logic [49:0] exp1_q[$];

  dmem_wait_ctrl #(.ADDR_W(13), .DEPTH(2048), .WAIT_CYCLES(W0)) u_dut (
    .clk_in(clk), .reset(reset), .cs(cs[0]), .rd(rd[0]), .wr(wr[0]),
    .dm_bit(dm[0]), .sext(sext[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]),
    .state_dbg(st[0])
  );

  dmem_wait_ctrl #(.ADDR_W(13), .DEPTH(2048), .WAIT_CYCLES(W1)) u_dut0 (
    .clk_in(clk), .reset(reset), .cs(cs[1]), .rd(rd[1]), .wr(wr[1]),
    .dm_bit(dm[1]), .sext(sext[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]),
    .state_dbg(st[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // scoreboard
  task automatic check_resp(input int u, input logic [49:0] e);
    logic [15:0] c16, lat;
    c16 = cyc[15:0];
    lat = c16 - e[15:0];
    chk($sformatf("u%0d err", u), {31'd0, err[u]}, {31'd0, e[48]});
    chk($sformatf("u%0d busy_at_ready", u), {31'd0, busy[u]}, 32'd1);
    if (e[49]) chk($sformatf("u%0d rdata", u), rdata[u], e[47:16]);
    chk($sformatf("u%0d latency", u), {16'd0, lat}, (u == 0) ? W0 + 1 : W1 + 1);
  endtask

  always @(negedge clk) begin
    if (reset && ready[0]) begin
      if (exp_q.size() == 0) chk("u0 unexpected_ready", 32'd1, 32'd0);
      else check_resp(0, exp_q.pop_front());
    end
    if (reset && ready[1]) begin
      if (exp1_q.size() == 0) chk("u1 unexpected_ready", 32'd1, 32'd0);
      else check_resp(1, exp1_q.pop_front());
    end
  end

  // driver
  task automatic wait_ready(input int u);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ready[u]) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk($sformatf("u%0d ready_timeout", u), 32'd0, 32'd1);
  endtask

  task automatic issue(input int u, input logic r, input logic w, input logic [1:0] size,
                       input logic sx, input logic [31:0] a, input logic [31:0] d,
                       input logic echk, input logic eerr, input logic [31:0] edata,
                       input bit glitch);
    logic [49:0] e;
    @(negedge clk);
    cs[u] = 1'b1; rd[u] = r; wr[u] = w; dm[u] = size; sext[u] = sx;
    addr[u] = a; wdata[u] = d;
    e = {echk, eerr, edata, cyc[15:0]};
    if (u == 0) exp_q.push_back(e);
    else        exp1_q.push_back(e);
    @(negedge clk);
    if (glitch) begin
      rd[u] = 1'b0; wr[u] = 1'b1; dm[u] = 2'b00;
      addr[u] = 32'h50; wdata[u] = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    cs[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
    wait_ready(u);
  endtask

  task automatic sw(input int u, input logic [31:0] a, input logic [31:0] d);
    issue(u, 1'b0, 1'b1, 2'b00, 1'b0, a, d, 1'b0, 1'b0, 32'd0, 0);
  endtask

  task automatic ld(input int u, input logic [1:0] size, input logic sx,
                    input logic [31:0] a, input logic [31:0] exp_d);
    issue(u, 1'b1, 1'b0, size, sx, a, 32'd0, 1'b1, 1'b0, exp_d, 0);
  endtask

  task automatic bad(input logic r, input logic w, input logic [1:0] size,
                     input logic [31:0] a, input logic [31:0] d);
    issue(0, r, w, size, 1'b0, a, d, 1'b1, 1'b1, 32'd0, 0);
  endtask

  initial begin
    reset = 1'b0;
    cs = '0; rd = '0; wr = '0; sext = '0; dm = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset ready", u), {31'd0, ready[u]}, 32'd0);
      chk($sformatf("u%0d reset busy", u), {31'd0, busy[u]}, 32'd0);
      chk($sformatf("u%0d reset err", u), {31'd0, err[u]}, 32'd0);
      chk($sformatf("u%0d reset rdata", u), rdata[u], 32'd0);
    end
    reset = 1'b1;

    // word store/load
    sw(0, 32'h10, 32'hDEAD_BEEF);
    ld(0, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);

    // byte/half loads with both extensions
    sw(0, 32'h20, 32'h80FF_7F01);
    ld(0, 2'b10, 1'b1, 32'h23, 32'hFFFF_FF80);
    ld(0, 2'b10, 1'b0, 32'h23, 32'h0000_0080);
    ld(0, 2'b01, 1'b1, 32'h22, 32'hFFFF_80FF);
    ld(0, 2'b01, 1'b0, 32'h22, 32'h0000_80FF);
    ld(0, 2'b01, 1'b1, 32'h20, 32'h0000_7F01);
    ld(0, 2'b10, 1'b1, 32'h21, 32'h0000_007F);
    ld(0, 2'b10, 1'b1, 32'h20, 32'h0000_0001);
    ld(0, 2'b00, 1'b1, 32'h20, 32'h80FF_7F01);

    // partial stores merge into the word
    sw(0, 32'h30, 32'h1122_3344);
    issue(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h31, 32'h1234_56AA, 1'b0, 1'b0, 32'd0, 0);
    issue(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h9999_BEEF, 1'b0, 1'b0, 32'd0, 0);
    ld(0, 2'b00, 1'b0, 32'h30, 32'hBEEF_AA44);

    // rejected accesses leave storage alone
    sw(0, 32'h40, 32'hA5A5_A5A5);
    bad(1'b1, 1'b0, 2'b01, 32'h41, 32'd0);
    bad(1'b0, 1'b1, 2'b00, 32'h42, 32'hFFFF_FFFF);
    bad(1'b1, 1'b1, 2'b00, 32'h40, 32'h0000_0000);
    bad(1'b0, 1'b1, 2'b11, 32'h40, 32'h0000_0000);
    ld(0, 2'b00, 1'b0, 32'h40, 32'hA5A5_A5A5);

    // address wrap and requests offered while busy
    sw(0, 32'h2000, 32'h5A5A_5A5A);
    ld(0, 2'b00, 1'b0, 32'h0000, 32'h5A5A_5A5A);
    sw(0, 32'h50, 32'h1234_5678);
    issue(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h50, 32'd0, 1'b1, 1'b0, 32'h1234_5678, 1);
    ld(0, 2'b00, 1'b0, 32'h50, 32'h1234_5678);

    // reset while a store is in flight
    sw(0, 32'h60, 32'hCAFE_F00D);
    @(negedge clk);
    cs[0] = 1'b1; wr[0] = 1'b1; dm[0] = 2'b00; addr[0] = 32'h60; wdata[0] = 32'h0BAD_BAD0;
    @(negedge clk);
    cs[0] = 1'b0; wr[0] = 1'b0;
    chk("u0 in_wait busy", {31'd0, busy[0]}, 32'd1);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("u0 midreset ready", {31'd0, ready[0]}, 32'd0);
      chk("u0 midreset busy", {31'd0, busy[0]}, 32'd0);
      chk("u0 midreset err", {31'd0, err[0]}, 32'd0);
    end
    reset = 1'b1;
    ld(0, 2'b00, 1'b0, 32'h60, 32'hCAFE_F00D);

    // zero wait states
    sw(1, 32'h10, 32'hDEAD_BEEF);
    ld(1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
    ld(1, 2'b10, 1'b1, 32'h13, 32'hFFFF_FFDE);

    repeat (4) @(negedge clk);
    chk("u0 queue_drained", exp_q.size(), 32'd0);
    chk("u1 queue_drained", exp1_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Parametrised data-memory block with a request/ready handshake.
- Configurable wait states, byte/half/word access, sign- or zero-extended loads, and alignment checking.
- Sits between the CPU data port (addr_dmem, wdata, DM_CS, DM_R, DM_W, DM_bit, rdata) and word-organised storage.
- Lets the core stall on slow memory instead of assuming single-cycle access.

Parameters:
- ADDR_W, 13, byte-address width used; word index is addr[ADDR_W-1:2].
- DEPTH, 2048, number of 32-bit words; must equal 2**(ADDR_W-2).
- WAIT_CYCLES, 2, extra cycles between accept and ready; 0 to 15 legal.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- cs  input  1  chip select; request valid only when high.
- rd  input  1  read request.
- wr  input  1  write request.
- dm_bit  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as error).
- sext  input  1  1 = sign-extend half/byte loads, 0 = zero-extend.
- addr  input  32  byte address; bits above ADDR_W-1 ignored.
- wdata  input  32  store data; byte uses [7:0], half uses [15:0].
- rdata  output  32  load result; valid only in the cycle ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from accept until and including the ready cycle.
- err  output  1  pulses with ready when the access was rejected.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE; rdata=0, ready=0, busy=0, err=0.
  - Any in-flight access is abandoned and no write is committed.
  - Storage contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Accept occurs when cs && (rd || wr).
  - At accept, register addr, wdata, dm_bit, sext, rd, wr.
  - busy rises in the following cycle.
  - Go to WAIT with cnt=WAIT_CYCLES, or to DONE directly if WAIT_CYCLES==0.
- WAIT:
  - cnt decrements each cycle; go to DONE when cnt reaches 1.
  - Latency: ready is asserted exactly WAIT_CYCLES+1 cycles after the accept edge.
- DONE:
  - ready=1 for one cycle.
  - A write commits to storage on this edge; read data is presented on rdata.
  - Return to IDLE.
  - A new request can be accepted in the cycle after DONE, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Inputs while busy are ignored and never queued; the requester holds or re-issues.
- Error conditions: rd && wr together, dm_bit==11, half with addr[0]==1, word with addr[1:0]!=0.
  - The full latency still elapses.
  - In DONE, ready=1 and err=1, rdata=0, and no storage write occurs.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte store writes one lane. Half store writes lanes {addr[1],0} and {addr[1],1}. Word store writes all four lanes.
  - Unwritten lanes keep their previous value.
- Loads:
  - Byte load extracts the lane and extends bit 7 (sext=1) or with zeros.
  - Half load extends bit 15 the same way.
  - Word load returns the full word; sext is ignored.
- Addresses wrap modulo DEPTH words.
- rdata holds its last value outside ready cycles; consumers must sample only when ready=1.
- cs low with rd/wr high is ignored; rd=wr=0 with cs high is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - dm_bit encodings: DM_WORD=2'b00, DM_HALF=2'b01, DM_BYTE=2'b10.
  - State enum: IDLE, WAIT, DONE.
- One natural sub-module, dmem_lane_ram: DEPTH x 32 synchronous RAM with 4-bit byte-write-enable and registered read.
- Lane select, extension and alignment check stay in dmem_wait_ctrl.

Test Plan:
- Word store/load, WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10.
  - ready occurs 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
- Byte and half loads: store 0x80FF7F01 to 0x20.
  - Byte load at 0x23 with sext=1 returns 0xFFFFFF80; with sext=0 returns 0x00000080.
  - Half load at 0x22 with sext=1 returns 0xFFFF80FF.
- Partial stores: after a word store of 0x11223344 at 0x30, byte store 0xAA at 0x31 and half store 0xBEEF at 0x32.
  - Word load at 0x30 returns 0xBEEFAA44.
- Misalignment and error cases: half load at 0x41, word store at 0x42, rd&&wr together, and dm_bit=11.
  - Each gives ready=1, err=1, rdata=0; a word load at 0x40 shows contents unchanged.
- Wrap and busy: store 0x5A5A5A5A to byte address 0x2000 (DEPTH=2048), then load 0x0000.
  - Returns 0x5A5A5A5A.
  - A second request toggled during busy is not executed.
- Reset mid-operation: issue a word store, drop reset in the WAIT state, release it, then load the same address.
  - Old value is returned; ready, busy and err were 0 during reset.
  - Repeat the word store/load scenario with WAIT_CYCLES=0: ready comes on the cycle after accept.
